// File: rtl/led_pkg.sv
// Shared types and helpers for the switch-to-LED controller.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF      = 2'b00,
    LED_FOLLOW   = 2'b01,
    LED_BLINK_SW = 2'b10,
    LED_BLINK    = 2'b11
  } led_mode_t;

  function automatic int cnt_w(int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Switch/mode inputs and LED/debounce/tick outputs of led_blink_ctrl.
interface led_blink_ctrl_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0]   sw_i;
  logic [2*N_CH-1:0] mode_i;
  logic [N_CH-1:0]   led_o;
  logic [N_CH-1:0]   sw_db_o;
  logic              tick_o;

  modport master (
    output sw_i, mode_i,
    input  led_o, sw_db_o, tick_o
  );

  modport slave (
    input  sw_i, mode_i,
    output led_o, sw_db_o, tick_o
  );

endinterface

// File: rtl/led_channel.sv
// One channel: sync, debounce (LED_DEBOUNCE_EN), blink engine, LED register.
module led_channel
  import led_pkg::*;
#(
  parameter int DEB_TICKS   = 4,
  parameter int BLINK_TICKS = 250
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      tick_i,
  input  logic      sw_i,
  input  led_mode_t mode_i,
  output logic      led_o,
  output logic      sw_db_o
);

  localparam int BW = cnt_w(BLINK_TICKS);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);

  logic          s1_q, s2_q;
  logic          db;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ph_q, ph_d;
  logic          led_q, led_d;
  logic          act;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
    end
  end

`ifdef LED_DEBOUNCE_EN
  localparam int DW = cnt_w(DEB_TICKS);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_TICKS - 1);

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          db_q, db_d;

  always_comb begin
    dcnt_d = dcnt_q;
    db_d   = db_q;
    if (tick_i) begin
      if (s2_q == db_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == D_LAST) begin
        db_d   = ~db_q;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dcnt_q <= '0;
      db_q   <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      db_q   <= db_d;
    end
  end

  assign db = db_q;
`else
  // No filter: the synchroniser output is the accepted switch state.
  if (DEB_TICKS < 1) begin : g_deb_unused
  end
  assign db = s2_q;
`endif

  assign act = (mode_i == LED_BLINK) ||
               ((mode_i == LED_BLINK_SW) && db);

  // Idle blink engine parks in the on phase so blinking starts lit.
  always_comb begin
    bcnt_d = bcnt_q;
    ph_d   = ph_q;
    if (!act) begin
      bcnt_d = '0;
      ph_d   = 1'b1;
    end else if (tick_i) begin
      if (bcnt_q == B_LAST) begin
        bcnt_d = '0;
        ph_d   = ~ph_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    led_d = 1'b0;
    unique case (mode_i)
      LED_OFF:      led_d = 1'b0;
      LED_FOLLOW:   led_d = db;
      LED_BLINK_SW: led_d = ph_q & db;
      LED_BLINK:    led_d = ph_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bcnt_q <= '0;
      ph_q   <= 1'b1;
      led_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      ph_q   <= ph_d;
      led_q  <= led_d;
    end
  end

  assign led_o   = led_q;
  assign sw_db_o = db;

endmodule

// File: rtl/led_blink_ctrl.sv
// N_CH switch-to-LED controller with shared tick prescaler.
// Optional switch debounce enabled by defining LED_DEBOUNCE_EN.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int DEB_TICKS   = 4,
  parameter int BLINK_TICKS = 250
) (
  input logic              CLK,
  input logic              RST,
  led_blink_ctrl_if.slave  bus
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = cnt_w(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  assign pre_d  = (pre_q == P_LAST) ? '0 : pre_q + 1'b1;
  // Registered tick high exactly while the count sits at DIV-1.
  assign tick_d = (pre_d == P_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign bus.tick_o = tick_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    led_channel #(
      .DEB_TICKS   (DEB_TICKS),
      .BLINK_TICKS (BLINK_TICKS)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .tick_i  (tick_q),
      .sw_i    (bus.sw_i[k]),
      .mode_i  (led_mode_t'(bus.mode_i[2*k +: 2])),
      .led_o   (bus.led_o[k]),
      .sw_db_o (bus.sw_db_o[k])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl (DIV=5, DEB=3, BLINK=2, 4 ch).
// Expectations cover both LED_DEBOUNCE_EN builds.
module tb_led_blink_ctrl;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  led_blink_ctrl_if #(.N_CH(4)) bus ();

  led_blink_ctrl #(
    .N_CH        (4),
    .CLK_FREQ_HZ (50),
    .TICK_HZ     (10),
    .DEB_TICKS   (3),
    .BLINK_TICKS (2)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int         due;
    int         sel;
    logic [3:0] exp;
    string      nm;
  } chk_t;

  chk_t       sb[$];
  int         cyc    = 0;
  int         n_cmp  = 0;
  int         n_bad  = 0;
  logic [3:0] mon_act;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  function automatic logic [3:0] pick(int sel);
    if (sel == 0) return bus.led_o;
    if (sel == 1) return bus.sw_db_o;
    return {3'b000, bus.tick_o};
  endfunction

  task automatic exp_at(int due, int sel, logic [3:0] e, string nm);
    chk_t c;
    c.due = due;
    c.sel = sel;
    c.exp = e;
    c.nm  = nm;
    sb.push_back(c);
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge CLK);
  endtask

  // Monitor: compares every queued expectation on its due cycle.
  initial forever begin
    @(negedge CLK);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        n_cmp++;
        mon_act = pick(sb[i].sel);
        if (sb[i].due < cyc || mon_act !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s cyc %0d: got %b want %b",
                   sb[i].nm, cyc, mon_act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    RST        = 1'b1;
    bus.sw_i   = 4'hF;
    bus.mode_i = 8'h00;
    exp_at(3, 0, 4'b0000, "rst_led");
    exp_at(3, 1, 4'b0000, "rst_db");
    exp_at(3, 2, 4'b0000, "rst_tick");
    wait_cyc(3);
    RST        = 1'b0;
    bus.sw_i   = 4'h0;
    bus.mode_i = 8'h55;
    exp_at(6, 2, 4'b0000, "tick_pre");
    exp_at(7, 2, 4'b0001, "tick_first");
    exp_at(8, 2, 4'b0000, "tick_after");
    exp_at(12, 2, 4'b0001, "tick_second");
    exp_at(17, 2, 4'b0001, "tick_third");

    // Follow on channel 0
    wait_cyc(20);
    bus.sw_i[0] = 1'b1;
`ifdef LED_DEBOUNCE_EN
    exp_at(32, 1, 4'b0000, "fol_db_early");
    exp_at(33, 1, 4'b0001, "fol_db");
    exp_at(33, 0, 4'b0000, "fol_led_early");
    exp_at(34, 0, 4'b0001, "fol_led");
`else
    exp_at(21, 1, 4'b0000, "fol_db_early");
    exp_at(22, 1, 4'b0001, "fol_db");
    exp_at(22, 0, 4'b0000, "fol_led_early");
    exp_at(23, 0, 4'b0001, "fol_led");
`endif

    // Glitch on channel 1
    wait_cyc(40);
    bus.sw_i[1] = 1'b1;
`ifdef LED_DEBOUNCE_EN
    exp_at(45, 1, 4'b0001, "gl_db_a");
    exp_at(50, 1, 4'b0001, "gl_db_b");
    exp_at(53, 1, 4'b0001, "gl_db_c");
    exp_at(55, 1, 4'b0001, "gl_db_d");
    exp_at(55, 0, 4'b0001, "gl_led");
    wait_cyc(50);
    bus.sw_i[1] = 1'b0;
`else
    exp_at(41, 1, 4'b0001, "gl_db_pre");
    exp_at(42, 1, 4'b0011, "gl_db_pass");
    exp_at(43, 1, 4'b0001, "gl_db_end");
    exp_at(43, 0, 4'b0011, "gl_led_pass");
    exp_at(44, 0, 4'b0001, "gl_led_end");
    wait_cyc(41);
    bus.sw_i[1] = 1'b0;
`endif

    // Blink-always on channel 2, then off mid on-phase
    exp_at(60, 0, 4'b0001, "bk_idle");
    exp_at(61, 0, 4'b0101, "bk_on0");
    exp_at(68, 0, 4'b0101, "bk_on0_end");
    exp_at(69, 0, 4'b0001, "bk_off0");
    exp_at(78, 0, 4'b0001, "bk_off0_end");
    exp_at(79, 0, 4'b0101, "bk_on1");
    exp_at(88, 0, 4'b0101, "bk_on1_end");
    exp_at(89, 0, 4'b0001, "bk_off1");
    exp_at(102, 0, 4'b0101, "bk_mid_on");
    exp_at(103, 0, 4'b0001, "bk_mode_off");
    wait_cyc(60);
    bus.mode_i = 8'h75;
    wait_cyc(102);
    bus.mode_i = 8'h45;

    // Blink-on-switch on channel 3
`ifdef LED_DEBOUNCE_EN
    exp_at(122, 1, 4'b0001, "bs_db_early");
    exp_at(123, 1, 4'b1001, "bs_db");
    exp_at(123, 0, 4'b0001, "bs_led_early");
    exp_at(124, 0, 4'b1001, "bs_on0");
    exp_at(133, 0, 4'b1001, "bs_on0_end");
    exp_at(134, 0, 4'b0001, "bs_off0");
    exp_at(143, 0, 4'b0001, "bs_off0_end");
    exp_at(144, 0, 4'b1001, "bs_on1");
    exp_at(160, 0, 4'b0001, "bs_rel_off");
    exp_at(162, 1, 4'b1001, "bs_rel_db_hold");
    exp_at(163, 1, 4'b0001, "bs_rel_db");
    exp_at(164, 0, 4'b0001, "bs_rel_led");
`else
    exp_at(111, 1, 4'b0001, "bs_db_early");
    exp_at(112, 1, 4'b1001, "bs_db");
    exp_at(112, 0, 4'b0001, "bs_led_early");
    exp_at(113, 0, 4'b1001, "bs_on0");
    exp_at(118, 0, 4'b1001, "bs_on0_end");
    exp_at(119, 0, 4'b0001, "bs_off0");
    exp_at(129, 0, 4'b1001, "bs_on1");
    exp_at(147, 1, 4'b1001, "bs_rel_db_hold");
    exp_at(148, 1, 4'b0001, "bs_rel_db");
    exp_at(149, 0, 4'b0001, "bs_rel_led");
`endif
    wait_cyc(110);
    bus.mode_i  = 8'h85;
    bus.sw_i[3] = 1'b1;
    wait_cyc(146);
    bus.sw_i[3] = 1'b0;

    // Reset mid-operation
    wait_cyc(168);
    exp_at(170, 0, 4'b0001, "mr_led_pre");
    exp_at(170, 1, 4'b0001, "mr_db_pre");
    exp_at(171, 0, 4'b0000, "mr_led");
    exp_at(171, 1, 4'b0000, "mr_db");
    exp_at(171, 2, 4'b0000, "mr_tick");
    exp_at(174, 2, 4'b0000, "mr_tick_pre");
    exp_at(175, 2, 4'b0001, "mr_tick_first");
    wait_cyc(170);
    RST = 1'b1;
    wait_cyc(171);
    RST = 1'b0;

    wait_cyc(180);
    @(negedge CLK);
    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL leftover: %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
